// File: rtl/key_press_arbiter.sv
// Push-button front end: per-key synchronizer and rising-edge detector, pending latch,
// and a round-robin valid/ready offer. Optional debounce filter is enabled by KEY_DEBOUNCE_EN.
module key_press_arbiter #(
    parameter int N_KEYS          = 4,
    parameter int IDX_W           = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] keys_in,
    output logic              press_valid,
    output logic [IDX_W-1:0]  press_idx,
    input  logic              press_ready,
    output logic [N_KEYS-1:0] pending,
    output logic              drop_pulse
);

    generate
        if (N_KEYS < 2 || N_KEYS > 16 || IDX_W != $clog2(N_KEYS) ||
            DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
            $error("key_press_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [N_KEYS-1:0] sync1_q, sync2_q, prev_q;
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [N_KEYS-1:0] stable_w, edge_w, xfer_mask;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;
    logic              xfer, lock;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  pick;
    logic              pick_found;

`ifdef KEY_DEBOUNCE_EN
    logic [N_KEYS-1:0] stable_q;
    logic [7:0]        cnt_q [N_KEYS];

    // A new level is accepted only after it has differed from the filtered level
    // for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stable_q <= '0;
            for (int k = 0; k < N_KEYS; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (sync2_q[k] != stable_q[k]) begin
                    if (cnt_q[k] == 8'(DEBOUNCE_CYCLES - 1)) begin
                        stable_q[k] <= sync2_q[k];
                        cnt_q[k]    <= '0;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + 8'd1;
                    end
                end else begin
                    cnt_q[k] <= '0;
                end
            end
        end
    end

    assign stable_w = stable_q;
`else
    assign stable_w = sync2_q;
`endif

    assign edge_w = stable_w & ~prev_q;

    always_comb begin
        int c;
        c          = 0;
        xfer       = valid_q & press_ready;
        lock       = valid_q & ~press_ready;
        xfer_mask  = '0;
        if (xfer) xfer_mask[idx_q] = 1'b1;

        // A press on a key that is being delivered this cycle is kept, not dropped.
        pending_d = (pending_q & ~xfer_mask) | edge_w;
        drop_d    = |(edge_w & pending_q & ~xfer_mask);

        rr_d = rr_q;
        if (xfer) rr_d = (idx_q == IDX_W'(N_KEYS - 1)) ? '0 : idx_q + 1'b1;

        pick       = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            c = int'(rr_d) + i;
            if (c >= N_KEYS) c = c - N_KEYS;
            if (!pick_found && pending_d[c]) begin
                pick       = IDX_W'(c);
                pick_found = 1'b1;
            end
        end

        // An unaccepted offer is frozen; idx_q doubles as the held index.
        if (lock) begin
            valid_d = 1'b1;
            idx_d   = idx_q;
        end else begin
            valid_d = |pending_d;
            idx_d   = pick;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            rr_q      <= '0;
            drop_q    <= 1'b0;
        end else begin
            sync1_q   <= keys_in;
            sync2_q   <= sync1_q;
            prev_q    <= stable_w;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
            drop_q    <= drop_d;
        end
    end

    assign press_valid = valid_q;
    assign press_idx   = idx_q;
    assign pending     = pending_q;
    assign drop_pulse  = drop_q;

endmodule

// File: tb/tb_key_press_arbiter.sv
// Randomised and directed bench for key_press_arbiter against a cycle-level reference model.
module tb_key_press_arbiter;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int DEB = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [N-1:0]  keys_in;
    logic          press_valid;
    logic [IW-1:0] press_idx;
    logic          press_ready;
    logic [N-1:0]  pending;
    logic          drop_pulse;

    int vectors     = 0;
    int miscompares = 0;

    key_press_arbiter #(.N_KEYS(N), .IDX_W(IW), .DEBOUNCE_CYCLES(DEB)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .keys_in     (keys_in),
        .press_valid (press_valid),
        .press_idx   (press_idx),
        .press_ready (press_ready),
        .pending     (pending),
        .drop_pulse  (drop_pulse)
    );

    always #5 Clock = ~Clock;

    // Reference model: key samples from recent edges, pending set, current offer.
    logic [N-1:0] samp0, samp1, samp2;
    logic [N-1:0] stab, pstab;
    int           run [N];
    logic [N-1:0] m_pend;
    int           m_rr, m_idx;
    bit           m_valid, m_drop, live;

    task automatic model_step();
        logic [N-1:0] edges, xm;
        bit hold, found;
        if (Reset) begin
            samp0 = '0; samp1 = '0; samp2 = '0; stab = '0; pstab = '0;
            for (int k = 0; k < N; k++) run[k] = 0;
            m_pend = '0; m_rr = 0; m_idx = 0; m_valid = 0; m_drop = 0;
            live = 1;
            return;
        end
`ifdef KEY_DEBOUNCE_EN
        edges = stab & ~pstab;
        pstab = stab;
        for (int k = 0; k < N; k++) begin
            if (samp1[k] != stab[k]) begin
                if (run[k] == DEB - 1) begin stab[k] = samp1[k]; run[k] = 0; end
                else run[k] = run[k] + 1;
            end else run[k] = 0;
        end
`else
        edges = samp1 & ~samp2;
`endif
        samp2 = samp1; samp1 = samp0; samp0 = keys_in;
        xm = '0;
        if (m_valid && press_ready) begin
            xm[m_idx] = 1'b1;
            m_rr = (m_idx + 1) % N;
        end
        hold   = m_valid && !press_ready;
        m_drop = |(edges & m_pend & ~xm);
        m_pend = (m_pend & ~xm) | edges;
        if (!hold) begin
            m_valid = |m_pend;
            m_idx = 0;
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && m_pend[(m_rr + i) % N]) begin
                    m_idx = (m_rr + i) % N;
                    found = 1;
                end
            end
        end
    endtask

    initial begin
        live = 0;
        forever begin
            @(posedge Clock);
            model_step();
            #1;
            if (live) begin
                vectors++;
                if (press_valid !== m_valid || press_idx !== IW'(m_idx) ||
                    pending !== m_pend || drop_pulse !== m_drop) begin
                    miscompares++;
                    $display("FAIL model t=%0t: got valid=%b idx=%0d pend=%b drop=%b, expected valid=%b idx=%0d pend=%b drop=%b",
                             $time, press_valid, press_idx, pending, drop_pulse,
                             m_valid, m_idx, m_pend, m_drop);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    int drops;
    int rdy_pct;

    initial begin
        Reset = 1'b1; keys_in = '0; press_ready = 1'b0;
        tick(1);
        check("reset_valid", 32'(press_valid), 0);
        check("reset_idx",   32'(press_idx),   0);
        check("reset_pend",  32'(pending),     0);
        check("reset_drop",  32'(drop_pulse),  0);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_quiet", {press_valid, drop_pulse, pending}, 0);
        end

`ifndef KEY_DEBOUNCE_EN
        // Single key: offer appears after the third edge, then only once while held.
        keys_in = 4'b0100; press_ready = 1'b1;
        tick(2);
        check("lat_early", 32'(press_valid), 0);
        tick(1);
        check("lat_valid", 32'(press_valid), 1);
        check("lat_idx",   32'(press_idx),   2);
        check("lat_pend",  32'(pending),     32'b0100);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("held_once", 32'(press_valid), 0);
        end

        // Three keys at once, offer frozen while not ready, then round-robin drain.
        keys_in = '0; press_ready = 1'b0; Reset = 1'b1;
        tick(1);
        Reset = 1'b0; keys_in = 4'b1011;
        tick(3);
        check("multi_valid", 32'(press_valid), 1);
        check("multi_idx0",  32'(press_idx),   0);
        check("multi_pend",  32'(pending),     32'b1011);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("multi_hold", {press_valid, press_idx}, {1'b1, 2'd0});
        end
        press_ready = 1'b1;
        tick(1);
        check("drain_1", {press_valid, press_idx, pending}, {1'b1, 2'd1, 4'b1010});
        tick(1);
        check("drain_3", {press_valid, press_idx, pending}, {1'b1, 2'd3, 4'b1000});
        tick(1);
        check("drain_0", {press_valid, pending}, 0);

        // Re-press of a pending key is dropped with a single pulse.
        press_ready = 1'b0; keys_in = '0;
        tick(4);
        keys_in = 4'b0010;
        tick(3);
        check("drop_setup", {press_valid, press_idx, pending}, {1'b1, 2'd1, 4'b0010});
        keys_in = '0;
        tick(2);
        keys_in = 4'b0010;
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (drop_pulse === 1'b1) drops++;
            check("drop_hold", {press_valid, press_idx, pending}, {1'b1, 2'd1, 4'b0010});
        end
        check("drop_count", 32'(drops), 1);

        // Locked offer ignores a later press; reset clears an unaccepted offer.
        press_ready = 1'b1;
        tick(1);
        press_ready = 1'b0; keys_in = '0;
        tick(3);
        keys_in = 4'b0001;
        tick(3);
        check("lock_idx0", {press_valid, press_idx, pending}, {1'b1, 2'd0, 4'b0001});
        keys_in = 4'b1001;
        tick(4);
        check("lock_keep", {press_valid, press_idx, pending}, {1'b1, 2'd0, 4'b1001});
        press_ready = 1'b1;
        tick(1);
        check("lock_next3", {press_valid, press_idx, pending}, {1'b1, 2'd3, 4'b1000});
        press_ready = 1'b0;
        tick(1);
        Reset = 1'b1;
        tick(1);
        check("mid_reset", {press_valid, press_idx, pending}, 0);
        Reset = 1'b0;
`else
        // Short bounce is filtered; a held press appears after 3 + DEB edges.
        keys_in = 4'b0010;
        tick(2);
        keys_in = '0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            check("bounce_quiet", 32'(press_valid), 0);
        end
        keys_in = 4'b0010;
        tick(6);
        check("deb_early", 32'(press_valid), 0);
        tick(1);
        check("deb_valid", {press_valid, press_idx}, {1'b1, 2'd1});
        press_ready = 1'b1;
        tick(1);
        check("deb_taken", 32'(pending), 0);
`endif

        // Randomised traffic against the model.
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rdy_pct = (c / 500 % 3 == 0) ? 10 : ((c / 500 % 3 == 1) ? 50 : 90);
            press_ready = ($urandom_range(0, 99) < rdy_pct);
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 7) == 0) keys_in[k] = ~keys_in[k];
            Reset = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        Reset = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
